// File: rtl/display_scan_scheduler_if.sv
// rtl/display_scan_scheduler_if.sv - requester bus between value sources and the display scheduler
//
// Purpose: groups the two requester request/value pairs and their grants.
// Signals:
//   req_a, val_a[15:0] : requester A (OTP code, priority source)
//   req_b, val_b[15:0] : requester B (countdown/status value)
//   grant_a, grant_b   : current display owner, never both high
// Modports:
//   master : requester side (drives requests/values, observes grants)
//   slave  : scheduler side (observes requests/values, drives grants)
interface display_scan_scheduler_if;
  logic        req_a;
  logic [15:0] val_a;
  logic        req_b;
  logic [15:0] val_b;
  logic        grant_a;
  logic        grant_b;

  modport master (
    output req_a, val_a, req_b, val_b,
    input  grant_a, grant_b
  );

  modport slave (
    input  req_a, val_a, req_b, val_b,
    output grant_a, grant_b
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - two-source arbiter, double-dabble converter and 5-digit scan driver
//
// Purpose: grants the shared 5-digit BCD display to requester A (priority) or B,
// converts the granted 16-bit value to BCD one bit per clock and scans the
// digits onto a single digit bus with a one-hot select.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : 0 forces digit_bcd to blank (4'hF)
//   req_if     : requester bus (slave side), requests/values in, grants out
//   digit_sel  : one-hot digit select, bit0 = D1 (least significant)
//   digit_bcd  : BCD code of the selected digit, 4'hF = blank
//   busy       : high while a conversion (LOAD + 16 shifts) is in flight
module display_scan_scheduler #(
  parameter int SCAN_DIV   = 1000,
  parameter int HOLD_SCANS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  display_scan_scheduler_if.slave req_if,
  output logic [4:0]              digit_sel,
  output logic [3:0]              digit_bcd,
  output logic                    busy
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW  = $clog2(HOLD_SCANS + 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [SCW-1:0] SCAN_ONE  = SCW'(1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_SCANS);
  localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CONVERT,
    S_DISPLAY
  } state_e;

  state_e          state_q;
  logic            grant_a_q;
  logic            grant_b_q;
  logic            busy_q;
  logic [15:0]     val_q;
  logic [35:0]     shift_q;
  logic [3:0]      bit_cnt_q;
  logic [19:0]     buf_q;
  logic [SCW-1:0]  scan_cnt_q;
  logic [4:0]      digit_sel_q;
  logic [HW-1:0]   hold_q;

  logic            scan_tick;
  logic            scan_wrap;
  logic [35:0]     shift_d;
  logic [HW-1:0]   hold_d;
  logic            arb_to_a;
  logic            arb_to_b;
  logic            arb_switch;
  logic [3:0]      nib_sel;

  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign scan_wrap = scan_tick & digit_sel_q[4];

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < 5; i++) begin
      if (shift_q[16 + 4*i +: 4] >= 4'd5) begin
        shift_d[16 + 4*i +: 4] = shift_q[16 + 4*i +: 4] + 4'd3;
      end
    end
    shift_d = shift_d << 1;
  end

  // Hold count as it will be after this wrap (saturating).
  assign hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;

  // Wrap-time arbitration; A is never preempted, B yields to A only after the hold period.
  always_comb begin
    arb_to_a = 1'b0;
    arb_to_b = 1'b0;
    if (grant_a_q) begin
      if (req_if.req_a)      arb_to_a = 1'b1;
      else if (req_if.req_b) arb_to_b = 1'b1;
    end else begin
      if (!req_if.req_b)                          arb_to_a = req_if.req_a;
      else if (req_if.req_a && hold_d == HOLD_MAX) arb_to_a = 1'b1;
      else                                        arb_to_b = 1'b1;
    end
  end

  assign arb_switch = (arb_to_a & ~grant_a_q) | (arb_to_b & ~grant_b_q);

  // Digit scan runs in every state, independent of conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= 5'b00001;
    end else if (scan_tick) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= {digit_sel_q[3:0], digit_sel_q[4]};
    end else begin
      scan_cnt_q  <= scan_cnt_q + SCAN_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      busy_q    <= 1'b0;
      val_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      buf_q     <= 20'hFFFFF;
      hold_q    <= '0;
    end else begin
      // Wraps that land mid-conversion still count toward the hold period,
      // but arbitration waits for the next wrap seen in DISPLAY.
      if (scan_wrap && (state_q inside {S_LOAD, S_CONVERT})) begin
        hold_q <= hold_d;
      end
      case (state_q)
        S_IDLE: begin
          if (req_if.req_a || req_if.req_b) begin
            grant_a_q <= req_if.req_a;
            grant_b_q <= ~req_if.req_a;
            val_q     <= req_if.req_a ? req_if.val_a : req_if.val_b;
            hold_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          shift_q   <= {20'b0, val_q};
          bit_cnt_q <= '0;
          state_q   <= S_CONVERT;
        end
        S_CONVERT: begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            buf_q   <= shift_d[35:16];
            busy_q  <= 1'b0;
            state_q <= S_DISPLAY;
          end
        end
        S_DISPLAY: begin
          if (scan_wrap) begin
            if (arb_to_a || arb_to_b) begin
              grant_a_q <= arb_to_a;
              grant_b_q <= arb_to_b;
              val_q     <= arb_to_a ? req_if.val_a : req_if.val_b;
              hold_q    <= arb_switch ? '0 : hold_d;
              busy_q    <= 1'b1;
              state_q   <= S_LOAD;
            end else begin
              grant_a_q <= 1'b0;
              grant_b_q <= 1'b0;
              hold_q    <= '0;
              buf_q     <= 20'hFFFFF;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    nib_sel = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (digit_sel_q[i]) nib_sel = buf_q[4*i +: 4];
    end
  end

  assign digit_bcd      = enable ? nib_sel : 4'hF;
  assign digit_sel      = digit_sel_q;
  assign busy           = busy_q;
  assign req_if.grant_a = grant_a_q;
  assign req_if.grant_b = grant_b_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb/tb_display_scan_scheduler.sv - randomized bench with a timestamp/decimal reference model
module tb_display_scan_scheduler;

  localparam int SD = 4;
  localparam int H  = 8;
  localparam int SCAN_LEN = 5 * SD;
  localparam int CONV_LAT = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] digit_sel;
  logic [3:0] digit_bcd;
  logic       busy;

  display_scan_scheduler_if bus ();

  display_scan_scheduler #(
    .SCAN_DIV   (SD),
    .HOLD_SCANS (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_if    (bus.slave),
    .digit_sel (digit_sel),
    .digit_bcd (digit_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: edge count since reset, owner (0 none, 1 A, 2 B),
  // hold count, shown digits and the digits due at edge m_done.
  int n;
  int m_owner;
  int m_hold;
  int m_done;
  int m_buf[5];
  int m_pend[5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_owner = 0;
    m_hold = 0;
    m_done = -1;
    for (int i = 0; i < 5; i++) m_buf[i] = 15;
  endtask

  task automatic model_start(input int v);
    int t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      m_pend[i] = t % 10;
      t = t / 10;
    end
    m_done = n + CONV_LAT;
  endtask

  task automatic model_arbitrate(input int hi);
    int nxt;
    if (m_owner == 1) nxt = bus.req_a ? 1 : (bus.req_b ? 2 : 0);
    else if (!bus.req_b) nxt = bus.req_a ? 1 : 0;
    else nxt = (bus.req_a && hi >= H) ? 1 : 2;
    if (nxt == 0) begin
      m_owner = 0;
      m_hold = 0;
      m_done = -1;
      for (int i = 0; i < 5; i++) m_buf[i] = 15;
    end else begin
      m_hold = (nxt == m_owner) ? hi : 0;
      m_owner = nxt;
      model_start(nxt == 1 ? int'(bus.val_a) : int'(bus.val_b));
    end
  endtask

  task automatic model_step();
    int hi;
    n++;
    if (m_owner == 0) begin
      if (bus.req_a) begin
        m_owner = 1; m_hold = 0; model_start(int'(bus.val_a));
      end else if (bus.req_b) begin
        m_owner = 2; m_hold = 0; model_start(int'(bus.val_b));
      end
    end else begin
      if (n == m_done) for (int i = 0; i < 5; i++) m_buf[i] = m_pend[i];
      if (n % SCAN_LEN == 0) begin
        hi = (m_hold + 1 > H) ? H : m_hold + 1;
        if (m_done >= n) m_hold = hi;
        else model_arbitrate(hi);
      end
    end
  endtask

  task automatic check_outputs();
    int idx;
    idx = (n / SD) % 5;
    check_eq("grant_a", bus.grant_a, m_owner == 1);
    check_eq("grant_b", bus.grant_b, m_owner == 2);
    check_eq("grant_excl", bus.grant_a & bus.grant_b, 0);
    check_eq("digit_sel", digit_sel, 1 << idx);
    check_eq("digit_bcd", digit_bcd, enable ? m_buf[idx] : 15);
    check_eq("busy", busy, (m_owner != 0) && (n < m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic run_random(input int k);
    repeat (k) begin
      if ($urandom_range(39) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(39) == 0) bus.req_b = ~bus.req_b;
      if ($urandom_range(7) == 0)  bus.val_a = 16'($urandom);
      if ($urandom_range(7) == 0)  bus.val_b = 16'($urandom);
      if ($urandom_range(99) == 0) enable = ~enable;
      tick();
    end
  endtask

  initial begin
    bit found;
    bus.req_a = 1'b0;
    bus.val_a = '0;
    bus.req_b = 1'b0;
    bus.val_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Maximum value: D5..D1 = 6,5,5,3,5.
    bus.req_a = 1'b1;
    bus.val_a = 16'd65535;
    run(80);

    // B alone with zero: five zero digits, 17-cycle busy per conversion.
    bus.req_a = 1'b0;
    bus.req_b = 1'b1;
    bus.val_b = 16'd0;
    run(120);

    // A arrives while B holds: switch only once the hold period has elapsed.
    run(2 * SCAN_LEN);
    bus.req_a = 1'b1;
    bus.val_a = 16'($urandom);
    run(10 * SCAN_LEN);

    // Mid-scan value change is picked up only at the next wrap.
    bus.val_a = 16'd12345;
    run(2 * SCAN_LEN);
    bus.val_a = 16'd54321;
    run(2 * SCAN_LEN);

    // Blanking with an active grant.
    enable = 1'b0;
    run(2 * SCAN_LEN);
    enable = 1'b1;

    // All requests dropped.
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    run(3 * SCAN_LEN);

    run_random(2000);

    // Reset asserted in the middle of a conversion.
    enable = 1'b1;
    bus.req_a = 1'b1;
    bus.val_a = 16'($urandom);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (m_owner != 0 && n < m_done && n > m_done - 10) found = 1'b1;
    end
    check_eq("reach_convert", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_grant_a", bus.grant_a, 0);
    check_eq("rst_grant_b", bus.grant_b, 0);
    check_eq("rst_digit_sel", digit_sel, 5'b00001);
    check_eq("rst_digit_bcd", digit_bcd, 4'hF);
    check_eq("rst_busy", busy, 0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(100);

    run_random(1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Shares the single 5-digit BCD display between two value requesters: A is the OTP code (priority), B is the countdown/status value.
- Converts the granted 16-bit binary value to five BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Time-multiplexes the digits onto one digit bus with a one-hot digit select for the multiplexed seven-segment driver.
- Digit code 4'hF means blank, consistent with the existing display path.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays selected (≥2).
- HOLD_SCANS, 8: minimum number of full 5-digit scans a grant is held before re-arbitration may switch source (≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  display enable; 0 forces blank output.
- req_a  in  1  requester A (OTP) wants display.
- val_a  in  16  requester A binary value.
- req_b  in  1  requester B wants display.
- val_b  in  16  requester B binary value.
- grant_a  out  1  A currently owns display.
- grant_b  out  1  B currently owns display.
- digit_sel  out  5  one-hot digit select; bit0 = least significant digit (D1), bit4 = D5.
- digit_bcd  out  4  BCD code of the selected digit; 4'hF = blank.
- busy  out  1  high while the conversion engine runs.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, grants 0, digit_sel=5'b00001, digit_bcd=4'hF, busy=0, display buffer all 4'hF, scan and hold counters 0.
- FSM states: IDLE, LOAD, CONVERT, DISPLAY.
- IDLE: if a request is present, grant the source (A wins when both request), latch its value, go to LOAD. Otherwise stay; buffer is blank.
- LOAD (1 cycle): shift register gets {20'b0, latched value}; bit counter = 0; busy=1.
- CONVERT (16 cycles): each cycle, add 3 to any BCD nibble ≥5, then shift left by 1. After the 16th shift:
  - Copy the five nibbles to the display buffer atomically.
  - busy=0; go to DISPLAY.
  - LOAD→buffer-update latency is 17 cycles.
- The display buffer changes only at end of CONVERT. Scanning never stops during conversion and shows the old buffer.
- DISPLAY: the scan counter counts SCAN_DIV cycles, then advances digit_sel (rotate left, bit4 wraps to bit0). Scanning also runs in IDLE/LOAD/CONVERT.
- At each scan wrap (bit4 → bit0), increment the hold counter (saturating at HOLD_SCANS) and re-arbitrate:
  - Current owner's request dropped: switch to the other if it requests, else go to IDLE (grants 0, buffer blanked).
  - Both request and owner is B with hold ≥ HOLD_SCANS: switch to A.
  - Owner is A: keep A while req_a is high (A is never preempted).
  - Owner is B with req_b high, and no switch per the rule above: keep B.
  - After arbitration, relatch the owner's value and go to LOAD. The display refreshes every scan.
  - On a source switch, the hold counter resets to 0.
- grant_a and grant_b are never both 1. They change only at a scan wrap or on IDLE exit.
- Value changes mid-scan are ignored until the next wrap relatch.
- enable=0: digit_bcd forced to 4'hF combinationally. FSM, scan and arbitration continue.
- digit_bcd = buffer nibble selected by digit_sel when enable=1. Leading zeros are displayed, not blanked.
- Range: full 0..65535. 65535 gives D5..D1 = 6,5,5,3,5; no overflow is possible.
- Reset mid-CONVERT: everything returns to reset values immediately; no partial buffer update.

Test Plan:
- Reset, req_a=1, val_a=16'd65535, SCAN_DIV=4 → grant_a=1; buffer update 17 cycles after LOAD; scan yields D1..D5 = 5,3,5,5,6.
- req_b=1, val_b=0, no A → grant_b=1; all five digits 0; busy high exactly 17 cycles per conversion.
- B granted, req_a asserted at scan 2 with HOLD_SCANS=8 → switch to A only at the 8th wrap; grants never overlap.
- A granted with val_a=12345, change val_a to 54321 mid-scan → digits keep 1,2,3,4,5 until the wrap plus 17 cycles, then show 54321.
- enable=0 with an active grant → digit_bcd=4'hF on every digit; digit_sel keeps rotating. All requests dropped → IDLE, grants 0, blank.
- Assert rst_n=0 during CONVERT → outputs return to reset values in the same cycle; after release, digit_bcd=4'hF until a new conversion completes.
